// File: rtl/circuit_sweep_pkg.sv
// Shared types and helpers for the exhaustive-sweep signature checker.
// Contents:
//   state_e    - sweep FSM states
//   DEF_POLY   - default MISR feedback polynomial
//   DEF_SEED   - default MISR seed
//   misr_step  - one MISR update, generic up to MISR_MAX_W bits
package circuit_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  localparam int unsigned MISR_MAX_W = 64;

  // Shift left, fold in the polynomial when the MSB of the w-bit register is
  // set, then xor in the data word. The result is masked to w bits.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic                  msb;
    mask = (w >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
    msb  = sig[6'(w - 1)];
    return (((sig << 1) ^ (msb ? poly : MISR_MAX_W'(0))) ^ data) & mask;
  endfunction

endpackage

// File: rtl/circuit_sweep_checker_misr.sv
// Multiple-input signature register used by the sweep checker.
// Ports:
//   clk, rst_n         - clock, async active-low reset (register resets to SEED)
//   load_i             - reload SEED (wins over enable_i)
//   enable_i           - fold data_i into the signature this cycle
//   data_i [DATA_W]    - response word, zero-extended to SIG_W
//   sig_o  [SIG_W]     - registered signature
//   sig_next_c_o       - combinational next value if enable_i were applied
module sweep_misr
  import circuit_sweep_pkg::*;
#(
  parameter int unsigned       SIG_W  = 16,
  parameter int unsigned       DATA_W = 5,
  parameter logic [SIG_W-1:0]  POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0]  SEED   = SIG_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SIG_W-1:0]  sig_o,
  output logic [SIG_W-1:0]  sig_next_c_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Single MISR step on the current register value.
  always_comb begin
    sig_next_c_o = SIG_W'(misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(data_i),
                                    MISR_MAX_W'(POLY), SIG_W));
  end

  // Next-state select: load, fold, or hold.
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (enable_i) begin
      sig_d = sig_next_c_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/circuit_sweep_checker.sv
// Exhaustive sweep driver/checker for a combinational circuit.
// Steps cut_in through every IN_W-bit vector, waits SETTLE cycles per vector,
// folds cut_out into a MISR, and compares the final signature to expected_sig.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   start             - begin a sweep (accepted in IDLE/DONE only)
//   abort             - cancel a sweep in progress
//   cut_in  [IN_W]    - registered stimulus to the CUT
//   cut_out [OUT_W]   - CUT response
//   expected_sig      - golden signature, sampled on DONE entry
//   busy, done, pass  - status (pass valid while done)
//   signature [SIG_W] - current MISR value
//   vec_idx [IN_W]    - vector currently applied
module circuit_sweep_checker
  import circuit_sweep_pkg::*;
#(
  parameter int unsigned      IN_W   = 5,
  parameter int unsigned      OUT_W  = 5,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter int unsigned      SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  input  logic [SIG_W-1:0] expected_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [IN_W-1:0]  vec_idx
);

  localparam int unsigned     CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [IN_W-1:0]  LAST_VEC    = '1;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             misr_load, misr_en;
  logic [SIG_W-1:0] sig_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks everything while a sweep is running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)               state_d = ST_IDLE;
        else if (wait_q == '0)   state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)                  state_d = ST_IDLE;
        else if (vec_q == LAST_VEC) state_d = ST_DONE;
        else                        state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and status next values.
  always_comb begin
    vec_d     = vec_q;
    wait_d    = wait_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d     = '0;
          wait_d    = WAIT_RELOAD;
          pass_d    = 1'b0;
          misr_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          pass_d = 1'b0;
        end else if (wait_q != '0) begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          pass_d = 1'b0;
        end else begin
          misr_en = 1'b1;
          if (vec_q == LAST_VEC) begin
            pass_d = (sig_next == expected_sig);
          end else begin
            vec_d  = vec_q + IN_W'(1);
            wait_d = WAIT_RELOAD;
          end
        end
      end
      default: begin
        pass_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      wait_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      wait_q <= wait_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  sweep_misr #(
    .SIG_W  (SIG_W),
    .DATA_W (OUT_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (misr_load),
    .enable_i     (misr_en),
    .data_i       (cut_out),
    .sig_o        (signature),
    .sig_next_c_o (sig_next)
  );

  assign cut_in  = vec_q;
  assign vec_idx = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;

endmodule

// File: doc/circuit_sweep_checker.md
Name: circuit_sweep_checker

Overview:
Drives every input vector into a combinational circuit-under-test (CUT), reads back the CUT outputs, and folds them into a multiple-input signature register (MISR).
- A single sweep covers the full space of 2^IN_W vectors.
- At the end of the sweep the block compares the signature against an expected value and reports pass/fail.
- It sits beside a generated combinational circuit: its stimulus port feeds the circuit's `in` bus, and its response port reads the circuit's `out` bus.

Parameters:
- IN_W, 5, width of the CUT input bus; the sweep covers 2^IN_W vectors.
- OUT_W, 5, width of the CUT output bus; must be <= SIG_W.
- SIG_W, 16, MISR and signature width.
- POLY, 16'h1021, MISR feedback polynomial (bit i set = tap i).
- SEED, 16'h0000, MISR value loaded at sweep start.
- SETTLE, 1, cycles to wait after applying a vector before sampling; must be >= 1.

Ports:
- clk, input, 1, single clock; all state on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a sweep; sampled in IDLE or DONE only.
- abort, input, 1, cancel a sweep in progress.
- cut_in, output, IN_W, registered stimulus vector to the CUT.
- cut_out, input, OUT_W, CUT response; combinational from cut_in.
- expected_sig, input, SIG_W, golden signature; sampled on entry to DONE.
- busy, output, 1, high in SETTLE and SAMPLE.
- done, output, 1, high while in DONE.
- pass, output, 1, signature == expected_sig; valid only while done = 1.
- signature, output, SIG_W, current MISR value.
- vec_idx, output, IN_W, vector currently applied (equals cut_in).

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - cut_in = 0, vec_idx = 0.
  - signature = SEED.
  - busy = 0, done = 0, pass = 0.
- States:
  - IDLE: start = 1 → load cut_in/vec_idx = 0, signature = SEED, wait_cnt = SETTLE-1 → SETTLE.
  - SETTLE:
    - If wait_cnt == 0 → SAMPLE.
    - Otherwise decrement wait_cnt.
    - SETTLE therefore lasts exactly SETTLE cycles.
  - SAMPLE (exactly one cycle):
    - MISR update: sig_next = (sig << 1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(cut_out).
    - If vec_idx == 2^IN_W-1 → DONE, with pass <= (sig_next == expected_sig).
    - Otherwise vec_idx/cut_in <= vec_idx+1, wait_cnt reloaded → SETTLE.
  - DONE:
    - done = 1; pass and signature hold.
    - start = 1 → same actions as start in IDLE; done drops the next cycle.
- Latency:
  - Each vector costs SETTLE+1 cycles.
  - done rises exactly 2^IN_W*(SETTLE+1) cycles after the cycle in which start was accepted.
  - Example: 64 cycles for the defaults.
- Wrap-around:
  - The vector counter never wraps during a sweep; the terminal vector is detected explicitly.
  - The counter width is IN_W+0; no overflow bit is needed.
- start while busy: ignored.
- abort:
  - Applies in SETTLE/SAMPLE: → IDLE next cycle, busy = 0, done stays 0, pass = 0.
  - signature holds its partial value; cut_in holds.
  - In IDLE/DONE abort is ignored.
- Simultaneous start and abort: abort has priority when busy; start has priority in IDLE/DONE.
- Reset mid-sweep: immediate return to reset values; no partial result is reported.
- cut_out is sampled only in SAMPLE; its value in SETTLE cycles is don't-care.

Decomposition:
- Shared package `circuit_sweep_pkg`:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}.
  - default POLY/SEED constants.
  - misr_step function: sig, data → next sig.
- One natural sub-module: `sweep_misr` (SIG_W/POLY/SEED parameters, load, enable, data in, sig out).
- The top module holds the FSM, vector counter and settle counter.

Test Plan:
1. Defaults, cut_out tied 0, SEED = 0, expected_sig = 0; pulse start → cut_in steps 0..31, each held 2 cycles; done rises 64 cycles after start; signature = 16'h0000; pass = 1.
2. IN_W = 1, SETTLE = 1, cut_out tied 1, SEED = 0 → signature sequence 0x0001, 0x0003; done after 4 cycles; expected_sig = 16'h0003 gives pass = 1, 16'h0002 gives pass = 0.
3. Defaults, cut_out = cut_in loopback; compare the signature against the bench misr_step model over vectors 0..31; then rerun with SETTLE = 3 → identical signature, done after 128 cycles.
4. Assert abort at vector 10 → busy = 0 and done = 0 the next cycle; a start pulse held during the sweep (before the abort) causes no restart; a subsequent start rerun gives the same result as a clean run.
5. Deassert rst_n asynchronously mid-SETTLE (not on a clock edge) → all outputs go to reset values immediately; signature = SEED.
6. In DONE, pulse start → done drops the next cycle, cut_in = 0, signature = SEED, and a new sweep completes with an identical signature.
